// File: rtl/stack_speed_ctrl.sv
// Speed and level controller for the block-stacking game.
// Tracks level and move period, shrinks the period on each stack (halve or
// subtract with a floor clamp), emits the per-period tick and runs the
// idle/play/over/win state machine.
module stack_speed_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned INIT_PERIOD = 200,
  parameter int unsigned MIN_PERIOD  = 4,
  parameter int unsigned STEP        = 16,
  parameter int unsigned LEVELS      = 15,
  parameter int unsigned LVL_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stacked,
  input  logic             miss,
  input  logic             mode,
  output logic [WIDTH-1:0] period,
  output logic [LVL_W-1:0] level,
  output logic             tick,
  output logic             playing,
  output logic             game_over,
  output logic             win
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StPlay = 2'd1;
  localparam logic [1:0] StOver = 2'd2;
  localparam logic [1:0] StWin  = 2'd3;

  localparam logic [WIDTH-1:0] InitP   = WIDTH'(INIT_PERIOD);
  localparam logic [WIDTH-1:0] MinP    = WIDTH'(MIN_PERIOD);
  localparam logic [WIDTH:0]   StepG   = (WIDTH + 1)'(STEP);
  localparam logic [LVL_W-1:0] LvlWin  = LVL_W'(LEVELS);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  logic [WIDTH-1:0] half_period;
  logic [WIDTH:0]   sub_diff;
  logic [WIDTH-1:0] sub_period;
  logic [LVL_W-1:0] level_inc;

  // Candidate next periods for both shrink rules, each clamped at the floor.
  always_comb begin
    half_period = period_q >> 1;
    if (half_period < MinP) begin
      half_period = MinP;
    end
    // Guard bit catches a borrow so the subtraction never wraps.
    sub_diff = {1'b0, period_q} - StepG;
    if (sub_diff[WIDTH] || (sub_diff[WIDTH-1:0] < MinP)) begin
      sub_period = MinP;
    end else begin
      sub_period = sub_diff[WIDTH-1:0];
    end
    level_inc = level_q + LVL_W'(1);
  end

  // Next-state logic for FSM, period, level, cycle counter and tick.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    case (state_q)
      StPlay: begin
        if (miss) begin
          // Miss dominates a simultaneous stack.
          state_d = StOver;
        end else if (stacked) begin
          // A stack restarts the period and suppresses any due tick.
          level_d = level_inc;
          cnt_d   = '0;
          if (level_inc == LvlWin) begin
            state_d = StWin;
          end else begin
            period_d = mode ? sub_period : half_period;
          end
        end else if (cnt_q == period_q - WIDTH'(1)) begin
          cnt_d  = '0;
          tick_d = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      default: begin
        if (start) begin
          state_d  = StPlay;
          period_d = InitP;
          level_d  = '0;
          cnt_d    = '0;
        end
      end
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      period_q <= InitP;
      level_q  <= '0;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
    end
  end

  assign period    = period_q;
  assign level     = level_q;
  assign tick      = tick_q;
  assign playing   = (state_q == StPlay);
  assign game_over = (state_q == StOver);
  assign win       = (state_q == StWin);

endmodule

// File: tb/tb_stack_speed_ctrl.sv
// Bench for stack_speed_ctrl: a behavioural model pushes the expected
// outputs of every clock edge into a queue; a negedge monitor pops and
// compares. Directed checks cover the listed scenarios, then random play.
module tb_stack_speed_ctrl;
  localparam int W      = 8;
  localparam int INIT   = 200;
  localparam int MINP   = 4;
  localparam int STEP   = 16;
  localparam int LEVELS = 15;
  localparam int LW     = 4;

  logic          clk = 1'b0;
  logic          rst, start, stacked, miss, mode;
  logic [W-1:0]  period;
  logic [LW-1:0] level;
  logic          tick, playing, game_over, win;

  always #5 clk = ~clk;

  stack_speed_ctrl #(
    .WIDTH(W), .INIT_PERIOD(INIT), .MIN_PERIOD(MINP), .STEP(STEP),
    .LEVELS(LEVELS), .LVL_W(LW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stacked(stacked), .miss(miss), .mode(mode),
    .period(period), .level(level), .tick(tick), .playing(playing),
    .game_over(game_over), .win(win)
  );

  typedef struct {
    int per;
    int lvl;
    int st;   // 0 idle, 1 play, 2 over, 3 win
    bit tk;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  int tick_seen = 0;

  // Model state: tick is due whenever a whole number of periods has elapsed
  // since the edge that (re)started the period.
  int m_st = 0, m_per = INIT, m_lvl = 0;
  int n = 0, anchor = 0;

  function automatic int next_per(input int p, input logic md);
    int r;
    if (md == 1'b0) r = p / 2;
    else            r = p - STEP;
    if (r < MINP) r = MINP;
    return r;
  endfunction

  always @(posedge clk) begin : model
    exp_t e;
    n = n + 1;
    e.tk = 1'b0;
    if (rst) begin
      m_st = 0; m_per = INIT; m_lvl = 0;
    end else if (m_st != 1) begin
      if (start) begin
        m_st = 1; m_per = INIT; m_lvl = 0; anchor = n;
      end
    end else if (miss) begin
      m_st = 2;
    end else if (stacked) begin
      m_lvl = m_lvl + 1;
      anchor = n;
      if (m_lvl == LEVELS) m_st = 3;
      else m_per = next_per(m_per, mode);
    end else if (((n - anchor) % m_per) == 0) begin
      e.tk = 1'b1;
    end
    e.per = m_per; e.lvl = m_lvl; e.st = m_st;
    q.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (n > 0) begin
      total = total + 1;
      if (q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL scoreboard_empty at edge %0d", n);
      end else begin
        e = q.pop_front();
        if (int'(period) != e.per || int'(level) != e.lvl || tick != e.tk ||
            playing != (e.st == 1) || game_over != (e.st == 2) || win != (e.st == 3)) begin
          bad = bad + 1;
          if (bad <= 30)
            $display("FAIL cycle_%0d got per=%0d lvl=%0d tick=%0b p/o/w=%0b%0b%0b want per=%0d lvl=%0d tick=%0b st=%0d",
                     n, period, level, tick, playing, game_over, win, e.per, e.lvl, e.tk, e.st);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    total = total + 1;
    if (act != req) begin
      bad = bad + 1;
      $display("FAIL %s got=%0d want=%0d", nm, act, req);
    end
  endtask

  // One clock with the given inputs; returns at posedge+1.
  task automatic step(input logic s, input logic k, input logic m, input logic md);
    start = s; stacked = k; miss = m; mode = md;
    @(posedge clk);
    #1;
    start = 1'b0; stacked = 1'b0; miss = 1'b0;
    if (tick) tick_seen = tick_seen + 1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0, mode);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_period", int'(period), INIT);
    chk("rst_level", int'(level), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_flags", int'({playing, game_over, win}), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int exp_halve[7] = '{100, 50, 25, 12, 6, 4, 4};

  initial begin
    rst = 1'b1; start = 1'b0; stacked = 1'b0; miss = 1'b0; mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_period", int'(period), INIT);
    chk("init_flags", int'({playing, game_over, win}), 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Tick spacing: ticks after start edges +200, +400, +600.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("start_playing", int'(playing), 1);
    tick_seen = 0;
    idle(610);
    chk("tick_count", tick_seen, 3);

    // Halve mode with random gaps, then start during play is ignored.
    for (int i = 0; i < 7; i++) begin
      idle($urandom_range(0, 250));
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("halve_%0d", i), int'(period), exp_halve[i]);
    end
    chk("halve_level", int'(level), 7);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("start_in_play_per", int'(period), 4);
    chk("start_in_play_lvl", int'(level), 7);

    // Miss, restart from OVER.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("miss_over", int'(game_over), 1);
    idle(20);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart_over_per", int'(period), INIT);
    chk("restart_over_lvl", int'(level), 0);

    // Reset mid-game at level 5.
    for (int i = 0; i < 5; i++) begin
      idle($urandom_range(0, 30));
      step(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
    end
    chk("pre_reset_lvl", int'(level), 5);
    reset_mid();

    // Subtract mode to WIN; the fifth stack lands exactly on a tick-due edge.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      if (i == 4) idle(m_per - 1);
      else idle($urandom_range(0, 40));
      step(1'b0, 1'b1, 1'b0, 1'b1);
      if (i == 11) chk("sub_12", int'(period), 8);
      if (i == 12) chk("sub_13", int'(period), 4);
      if (i == 13) chk("sub_14", int'(period), 4);
    end
    chk("win_flag", int'(win), 1);
    chk("win_level", int'(level), 15);
    chk("win_period", int'(period), 4);
    tick_seen = 0;
    idle(50);
    chk("win_no_ticks", tick_seen, 0);

    // Restart from WIN, then stacked+miss together at level 3.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart_win_per", int'(period), INIT);
    chk("restart_win_lvl", int'(level), 0);
    for (int i = 0; i < 3; i++) begin
      idle($urandom_range(0, 20));
      step(1'b0, 1'b1, 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("both_over", int'(game_over), 1);
    chk("both_level", int'(level), 3);
    chk("both_period", int'(period), 25);

    // Random play with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 249) == 0), 1'($urandom_range(0, 1)));
      if (i % 1000 == 999) reset_mid();
    end

    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stack_speed_ctrl.md
# stack_speed_ctrl

Parametrised speed and level controller for the block-stacking game. It tracks the current level and the current move period, and shortens the period on every successful stack using a selectable halve or subtract rule with a floor clamp. It generates the per-period `tick` that steps the moving block, and it runs the game-level state machine (idle, play, game over, win). It sits between the stack-detect logic, which supplies `stacked` and `miss`, and the block-motion/display logic, which consumes `tick`, `level` and the status flags.

## Interface
- `WIDTH`, 8, bit width of the period and of the internal cycle counter
- `INIT_PERIOD`, 200, period in clk cycles loaded on start; legal range `MIN_PERIOD <= INIT_PERIOD < 2^WIDTH`
- `MIN_PERIOD`, 4, floor the period never goes below; must be >= 1
- `STEP`, 16, decrement applied per stack in subtract mode
- `LEVELS`, 15, number of successful stacks needed to win
- `LVL_W`, 4, level width; must satisfy `2^LVL_W > LEVELS`

- `clk`  in  1  system clock; all state changes on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  single-cycle pulse that begins a new game
- `stacked`  in  1  single-cycle pulse for a correctly stacked block
- `miss`  in  1  single-cycle pulse for a failed stack
- `mode`  in  1  period-shrink rule: 0 = halve, 1 = subtract `STEP`
- `period`  out  WIDTH  current move period in clk cycles (registered)
- `level`  out  LVL_W  count of successful stacks this game (registered)
- `tick`  out  1  single-cycle pulse once per `period` cycles while playing
- `playing`  out  1  high in PLAY
- `game_over`  out  1  high in OVER
- `win`  out  1  high in WIN

## Operation
- FSM states: IDLE, PLAY, OVER, WIN. The three status flags are decoded from the registered state, so at most one is high at a time.
- Reset (async, any time, including mid-game):
  - state = IDLE, `period` = `INIT_PERIOD`, `level` = 0
  - `tick` = 0, counter = 0, all flags 0
- IDLE, OVER, WIN:
  - `start` moves to PLAY and loads `period` = `INIT_PERIOD`, `level` = 0, counter = 0.
  - Otherwise `period` and `level` hold their last values and `tick` stays 0.
  - `stacked` and `miss` are ignored.
- PLAY, counter:
  - The counter increments each cycle.
  - When counter == `period`-1, the counter returns to 0 and `tick` is registered high for the next cycle.
  - `start` is ignored in PLAY.
- PLAY, `stacked` (and `miss` low):
  - `level` increments.
  - If the new level == `LEVELS`, go to WIN; `period` holds.
  - Otherwise `period` updates from the `mode` value sampled in that cycle:
    - mode 0: `period` = max(`period`>>1, `MIN_PERIOD`)
    - mode 1: `period` = `MIN_PERIOD` if `period` < `STEP`+`MIN_PERIOD`, else `period`-`STEP`
  - Subtraction is evaluated with one guard bit, so it never wraps.
  - The counter clears to 0, and no tick is issued from that cycle.
- PLAY, `miss`: go to OVER; `period` and `level` hold.
- `stacked` and `miss` in the same cycle: `miss` wins, giving OVER with no level or period change.
- `stacked` coinciding with counter == `period`-1: the stack update wins and no tick is issued.

## Timing
- All outputs are registered and change only on the rising edge of `clk`, except for the asynchronous reset.
- `start` sampled at edge E0:
  - `playing` = 1 and `period` = `INIT_PERIOD` after E0.
  - The first `tick` is high for the cycle after edge E0+`period`; later ticks follow every `period` cycles.
- `stacked` at edge E:
  - The new `level` and `period` are visible after E.
  - The next tick uses the new period, counted from E.
- `miss` at edge E: `game_over` = 1 after E, and no further ticks.
- `tick` width is exactly one cycle. With `MIN_PERIOD` = 1, `tick` is high continuously in PLAY.

## Test plan
- **Reset mid-game:** assert `rst` in PLAY at level 5 -> immediately IDLE, `period`=200, `level`=0, `tick`=0, flags 0.
- **Tick spacing:** `start`, then no stacks -> `tick` pulses exactly every 200 cycles, each one cycle wide; first pulse 200 edges after start.
- **Halve mode:** `mode`=0, 7 stacks -> `period` 100, 50, 25, 12, 6, 4, 4 (clamp); `level` 7.
- **Subtract mode and win:** `mode`=1.
  - 12 stacks -> `period` 8.
  - 13th -> 4 (underflow clamp); 14th -> 4.
  - 15th -> WIN, `win`=1, `level`=15, `period`=4, ticks stop.
- **Simultaneous events:** `stacked`+`miss` together at level 3 -> OVER, `level`=3, `period` unchanged. `stacked` on a tick-due cycle -> no tick, counter restarts with the new period.
- **Restart from OVER/WIN:** `start` -> PLAY, `period`=200, `level`=0. `start` during PLAY -> no effect.
